// File: rtl/sync_fifo_mc_pkg.sv
// sync_fifo_mc_pkg: default geometry constants and count-slice helper for sync_fifo_mc
package sync_fifo_mc_pkg;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_WIDTH = ADDR_W + 1;
  localparam int MAX_CH = 16;
  function automatic logic [CNT_WIDTH-1:0] cnt_slice(input logic [MAX_CH*CNT_WIDTH-1:0] cv, input int c);
    return cv[c*CNT_WIDTH +: CNT_WIDTH];
  endfunction
endpackage

// File: rtl/sync_fifo_ch_ctrl.sv
// sync_fifo_ch_ctrl: one channel's pointers, occupancy, flags and sticky errors (in: clk rst_n srst_n err_clr wr_req rd_req; out: wr_ptr rd_ptr cnt full empty afull aempty ovf udf wr_ok rd_ok)
module sync_fifo_ch_ctrl
  import sync_fifo_mc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int AFULL_LVL = 2 ** ADDR_WIDTH - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst_n,
  input  logic                  err_clr,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   cnt,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic                  ovf,
  output logic                  udf,
  output logic                  wr_ok,
  output logic                  rd_ok
);
  localparam int CW = ADDR_WIDTH + 1;
  assign full = cnt == CW'(2 ** ADDR_WIDTH);
  assign empty = cnt == '0;
  assign afull = cnt >= CW'(AFULL_LVL);
  assign aempty = cnt <= CW'(AEMPTY_LVL);
  assign wr_ok = wr_req && !full;
  assign rd_ok = rd_req && !empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(wr_ok);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(rd_ok);
      cnt <= cnt + CW'(wr_ok) - CW'(rd_ok);
      ovf <= (ovf && !err_clr) || (wr_req && full);
      udf <= (udf && !err_clr) || (rd_req && empty);
    end
  end
endmodule

// File: rtl/sync_fifo_mc.sv
// sync_fifo_mc: NUM_CH logical FIFOs over one shared store (in: clk rst_n srst_n wr_* rd_en rd_ch err_clr; out: rd_data rd_valid rd_ch_out full empty afull aempty count ovf_err udf_err)
module sync_fifo_mc
  import sync_fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int NUM_CH = 4,
  parameter int CH_WIDTH = 2,
  parameter int AFULL_LVL = 2 ** ADDR_WIDTH - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           srst_n,
  input  logic                           wr_en,
  input  logic [CH_WIDTH-1:0]            wr_ch,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [CH_WIDTH-1:0]            rd_ch,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic [CH_WIDTH-1:0]            rd_ch_out,
  output logic [NUM_CH-1:0]              full,
  output logic [NUM_CH-1:0]              empty,
  output logic [NUM_CH-1:0]              afull,
  output logic [NUM_CH-1:0]              aempty,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count,
  output logic [NUM_CH-1:0]              ovf_err,
  output logic [NUM_CH-1:0]              udf_err,
  input  logic                           err_clr
);
  localparam int CW = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mem [2**(CH_WIDTH+ADDR_WIDTH)];
  logic [ADDR_WIDTH-1:0] wp [NUM_CH];
  logic [ADDR_WIDTH-1:0] rp [NUM_CH];
  logic [NUM_CH-1:0] wr_ok, rd_ok;
  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CW-1:0] cnt;
      sync_fifo_ch_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .AFULL_LVL(AFULL_LVL),
        .AEMPTY_LVL(AEMPTY_LVL)
      ) u_ctrl (
        .clk(clk),
        .rst_n(rst_n),
        .srst_n(srst_n),
        .err_clr(err_clr),
        .wr_req(wr_en && wr_ch == CH_WIDTH'(c)),
        .rd_req(rd_en && rd_ch == CH_WIDTH'(c)),
        .wr_ptr(wp[c]),
        .rd_ptr(rp[c]),
        .cnt(cnt),
        .full(full[c]),
        .empty(empty[c]),
        .afull(afull[c]),
        .aempty(aempty[c]),
        .ovf(ovf_err[c]),
        .udf(udf_err[c]),
        .wr_ok(wr_ok[c]),
        .rd_ok(rd_ok[c])
      );
      assign count[c*CW +: CW] = cnt;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (srst_n && |wr_ok) mem[{wr_ch, wp[wr_ch]}] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !srst_n) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_ch_out <= '0;
    end else begin
      rd_valid <= |rd_ok;
      if (|rd_ok) begin
        rd_data <= mem[{rd_ch, rp[rd_ch]}];
        rd_ch_out <= rd_ch;
      end
    end
  end
endmodule
